weight_ram_scheduler: RTL and testbench

WEIGHT_RAM_SCHEDULER -- requirements
Module: weight_ram_scheduler

---
 rtl/weight_ram_scheduler_pkg.sv | 9 +
 rtl/weight_ram_scheduler_sat_acc.sv | 24 ++
 rtl/weight_ram_scheduler.sv | 90 +++++++++
 tb/tb_weight_ram_scheduler.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/weight_ram_scheduler_pkg.sv
// weight_ram_scheduler_pkg: shared FSM state, default sizes and saturation limits
package weight_ram_scheduler_pkg;
  localparam int NEURON_ADR_DEF = 5;
  localparam int WEIGHTS_DEF = 31;
  localparam int ACC_W_DEF = 40;
  localparam logic [ACC_W_DEF-1:0] ACC_MAX_DEF = {1'b0, {(ACC_W_DEF-1){1'b1}}};
  localparam logic [ACC_W_DEF-1:0] ACC_MIN_DEF = {1'b1, {(ACC_W_DEF-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
endpackage

// File: rtl/weight_ram_scheduler_sat_acc.sv
// sat_acc: signed accumulator that clamps at the ACC_W two's-complement limits
module sat_acc
  import weight_ram_scheduler_pkg::*;
#(
  parameter int DW = WEIGHTS_DEF + 1,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [DW-1:0]    din,
  output logic [ACC_W-1:0] acc
);
  logic [ACC_W:0] sum;
  assign sum = {acc[ACC_W-1], acc} + {{(ACC_W+1-DW){din[DW-1]}}, din};
  // add one extra bit of headroom; disagreeing top bits mean overflow, clamp toward the true sign
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc <= '0;
    else if (clr) acc <= '0;
    else if (en) acc <= (sum[ACC_W] ^ sum[ACC_W-1]) ?
                        (sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}}) :
                        sum[ACC_W-1:0];
endmodule

// File: rtl/weight_ram_scheduler.sv
// weight_ram_scheduler: scans weight RAM under a spike mask, streams gated weights and accumulates them
module weight_ram_scheduler
  import weight_ram_scheduler_pkg::*;
#(
  parameter int NEURON_ADR = NEURON_ADR_DEF,
  parameter int WEIGHTS = WEIGHTS_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [2**(NEURON_ADR+1)-1:0] spike_vec,
  output logic                         busy,
  output logic                         done,
  output logic [ACC_W-1:0]             acc,
  output logic                         w_valid,
  input  logic                         w_ready,
  output logic [NEURON_ADR:0]          w_addr,
  output logic [WEIGHTS:0]             w_data,
  input  logic                         wr_req,
  output logic                         wr_ack,
  input  logic [NEURON_ADR:0]          wr_addr,
  input  logic [WEIGHTS:0]             wr_data,
  output logic                         ram_we,
  output logic [NEURON_ADR:0]          ram_a,
  output logic [WEIGHTS:0]             ram_di,
  output logic [NEURON_ADR:0]          ram_dpra,
  input  logic [WEIGHTS:0]             ram_dpo
);
  localparam int AW = NEURON_ADR + 1;
  localparam int DW = WEIGHTS + 1;
  localparam int DEPTH = 2**AW;
  state_t state, nxt;
  logic [DEPTH-1:0] mask;
  logic adv, accept, last;
  assign adv = !(w_valid && !w_ready);
  assign accept = (state == IDLE) && start;
  assign last = ram_dpra == {AW{1'b1}};
  assign busy = (state == SCAN) || (state == DRAIN);
  assign done = state == DONE;
  assign wr_ack = wr_req && (((state == IDLE) && !start) || (state == DONE));
  // next state: a stalled output beat freezes both the scan and the drain
  always_comb begin
    nxt = state;
    nxt = accept ? SCAN :
          (state == SCAN && adv && last) ? DRAIN :
          (state == DRAIN && adv) ? DONE :
          (state == DONE) ? IDLE : state;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // read pipeline, output stage and registered RAM write port
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mask <= '0;
      ram_dpra <= '0;
      w_valid <= 1'b0;
      w_addr <= '0;
      w_data <= '0;
      ram_we <= 1'b0;
      ram_a <= '0;
      ram_di <= '0;
    end else begin
      ram_we <= wr_ack;
      if (wr_ack) begin
        ram_a <= wr_addr;
        ram_di <= wr_data;
      end
      if (accept) begin
        mask <= spike_vec;
        ram_dpra <= '0;
        w_valid <= 1'b0;
      end else if (state == SCAN && adv) begin
        w_valid <= mask[ram_dpra];
        w_addr <= ram_dpra;
        w_data <= ram_dpo;
        if (!last) ram_dpra <= ram_dpra + 1'b1;
      end else if (state == DRAIN && adv) w_valid <= 1'b0;
    end
  sat_acc #(.DW(DW), .ACC_W(ACC_W)) u_acc (
    .clk(clk),
    .rst_n(rst_n),
    .clr(accept),
    .en(w_valid && w_ready),
    .din(w_data),
    .acc(acc)
  );
endmodule

// File: tb/tb_weight_ram_scheduler.sv
// tb_weight_ram_scheduler: directed self-checking bench with an external RAM model
module tb_weight_ram_scheduler;
  logic clk, rst_n, start, busy, done, w_valid, w_ready, wr_req, wr_ack, ram_we, load;
  logic [63:0] spike_vec;
  logic [33:0] acc;
  logic [5:0] w_addr, wr_addr, ram_a, ram_dpra;
  logic [31:0] w_data, wr_data, ram_di, ram_dpo;
  logic [31:0] ram [64];
  logic [31:0] exp_ram [64];
  int n_chk = 0;
  int n_fail = 0;
  localparam longint SMAX = (longint'(1) << 33) - 1;
  localparam longint SMIN = -(longint'(1) << 33);

  weight_ram_scheduler #(.NEURON_ADR(5), .WEIGHTS(31), .ACC_W(34)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .spike_vec(spike_vec),
    .busy(busy), .done(done), .acc(acc),
    .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_data(w_data),
    .wr_req(wr_req), .wr_ack(wr_ack), .wr_addr(wr_addr), .wr_data(wr_data),
    .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di),
    .ram_dpra(ram_dpra), .ram_dpo(ram_dpo)
  );

  always #5 clk = ~clk;
  assign ram_dpo = ram[ram_dpra];
  always @(posedge clk)
    if (load) ram <= exp_ram;
    else if (ram_we) ram[ram_a] <= ram_di;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic load_ram();
    @(negedge clk) load = 1;
    @(negedge clk) load = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " w_valid"}, w_valid, 0);
    chk({tag, " w_addr"}, w_addr, 0);
    chk({tag, " w_data"}, w_data, 0);
    chk({tag, " acc"}, acc, 0);
    chk({tag, " wr_ack"}, wr_ack, 0);
    chk({tag, " ram_we"}, ram_we, 0);
    chk({tag, " ram_a"}, ram_a, 0);
    chk({tag, " ram_di"}, ram_di, 0);
    chk({tag, " ram_dpra"}, ram_dpra, 0);
  endtask

  task automatic run_scan(input string tag, input logic [63:0] mask, input bit rnd, input bit do_wr);
    int c, nb, na, first, lo;
    longint a;
    bit fin, bad_ack;
    a = 0; nb = 0; na = 0; first = -1; fin = 0; bad_ack = 0; lo = -1;
    for (int i = 63; i >= 0; i--) if (mask[i]) lo = i;
    @(negedge clk);
    start = 1; spike_vec = mask;
    if (do_wr) begin
      wr_req = 1; wr_addr = 6'd5; wr_data = 32'd42;
      chk({tag, " start beats wr_req"}, wr_ack, 0);
    end
    @(negedge clk);
    start = 0; spike_vec = ~mask;
    chk({tag, " busy after start"}, busy, 1);
    c = 1;
    while (!fin && c < 1000) begin
      start = (c == 10);
      w_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (do_wr && wr_ack && !done) bad_ack = 1;
      if (w_valid && w_ready) begin
        while (na < 64 && !mask[na]) na++;
        chk({tag, " beat addr"}, w_addr, na);
        chk({tag, " beat data"}, w_data, exp_ram[na]);
        a = a + longint'(signed'(exp_ram[na]));
        a = a > SMAX ? SMAX : a < SMIN ? SMIN : a;
        nb++;
        if (first < 0) first = c;
        na++;
      end
      if (done) fin = 1;
      else begin
        @(negedge clk);
        c++;
      end
    end
    start = 0;
    chk({tag, " done seen"}, fin, 1);
    chk({tag, " beat count"}, nb, $countones(mask));
    chk({tag, " acc"}, acc, a[33:0]);
    chk({tag, " busy at done"}, busy, 0);
    if (!rnd) chk({tag, " done cycle"}, c, 66);
    if (!rnd && lo >= 0) chk({tag, " first beat cycle"}, first, lo + 2);
    if (do_wr) begin
      chk({tag, " no ack during scan"}, bad_ack, 0);
      chk({tag, " ack at done"}, wr_ack, 1);
    end
    @(negedge clk);
    chk({tag, " done one cycle"}, done, 0);
    if (do_wr) begin
      chk({tag, " ram_we"}, ram_we, 1);
      chk({tag, " ram_a"}, ram_a, 5);
      chk({tag, " ram_di"}, ram_di, 42);
      wr_req = 0;
      exp_ram[5] = 32'd42;
      @(negedge clk);
      chk({tag, " ram_we one cycle"}, ram_we, 0);
    end
    w_ready = 1;
  endtask

  initial begin
    bit found, early_done, ram_ok;
    clk = 0; rst_n = 1; start = 0; spike_vec = '0; w_ready = 1;
    wr_req = 0; wr_addr = '0; wr_data = '0; load = 0;
    for (int i = 0; i < 64; i++) exp_ram[i] = i;
    #1 rst_n = 0;
    #2 chk_reset("reset");
    load_ram();
    @(negedge clk) rst_n = 1;

    run_scan("ones", '1, 0, 0);
    chk("ones acc 2016", acc, 2016);

    exp_ram[3] = 32'd5; exp_ram[10] = 32'hFFFF_FFF9; exp_ram[63] = 32'd100;
    load_ram();
    run_scan("sparse", 64'h8000_0000_0000_0408, 0, 0);
    chk("sparse acc 98", acc, 98);

    for (int i = 0; i < 64; i++) exp_ram[i] = i;
    load_ram();
    run_scan("rnd ready", '1, 1, 0);
    chk("rnd ready acc 2016", acc, 2016);

    run_scan("zero mask", '0, 0, 0);
    chk("zero mask acc", acc, 0);

    run_scan("write", '1, 0, 1);
    run_scan("after write", '1, 0, 0);
    chk("after write acc", acc, 2053);

    for (int i = 0; i < 64; i++) exp_ram[i] = 32'h7FFF_FFFF;
    load_ram();
    run_scan("sat max", '1, 0, 0);
    chk("sat max acc", acc, 34'h1_FFFF_FFFF);
    for (int i = 0; i < 64; i++) exp_ram[i] = 32'h8000_0000;
    load_ram();
    run_scan("sat min", '1, 0, 0);
    chk("sat min acc", acc, 34'h2_0000_0000);

    for (int i = 0; i < 64; i++) exp_ram[i] = i;
    load_ram();
    @(negedge clk) begin start = 1; spike_vec = '1; end
    @(negedge clk) start = 0;
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      if (w_valid && w_addr == 6'd20) found = 1;
      else @(negedge clk);
    end
    chk("midscan beat 20 reached", found, 1);
    rst_n = 0;
    #1 chk_reset("midscan reset");
    early_done = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) early_done = 1;
    end
    chk("midscan no done", early_done, 0);
    ram_ok = 1;
    for (int i = 0; i < 64; i++) if (ram[i] !== exp_ram[i]) ram_ok = 0;
    chk("midscan ram untouched", ram_ok, 1);
    @(posedge clk);
    #1 rst_n = 1;
    run_scan("post reset", '1, 0, 0);
    chk("post reset acc", acc, 2016);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
